// File: rtl/dtcctf_trgunit_if.sv
// Trigger unit bundle: DTC trigger level and controls in, clean trigger and counters out.
interface dtcctf_trgunit_if #(
    parameter int CNT_W = 32,
    parameter int REJ_W = 16
);
    logic             dtctrg_in;
    logic             dtcclk_ok;
    logic             trg_enable;
    logic             cnt_clr;
    logic [15:0]      cfg;
    logic             trg_pulse;
    logic             trg_busy;
    logic [CNT_W-1:0] trg_count;
    logic [REJ_W-1:0] trg_reject_count;

    modport master (
        output dtctrg_in, dtcclk_ok, trg_enable, cnt_clr, cfg,
        input  trg_pulse, trg_busy, trg_count, trg_reject_count
    );

    modport slave (
        input  dtctrg_in, dtcclk_ok, trg_enable, cnt_clr, cfg,
        output trg_pulse, trg_busy, trg_count, trg_reject_count
    );
endinterface

// File: rtl/dtcctf_trgunit.sv
// DTC trigger conditioner: 2-FF sync, min-width filter, deadtime veto, counters.
// All outputs are registered on clk0.
module dtcctf_trgunit #(
    parameter int CNT_W = 32,
    parameter int REJ_W = 16
) (
    input  logic clk0,
    input  logic rst,
    dtcctf_trgunit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, DEAD} state_e;

    state_e           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [7:0]       dcnt_q, dcnt_d;
    logic [7:0]       w_q, w_d;
    logic [7:0]       d_q, d_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REJ_W-1:0] rej_q, rej_d;

    logic       s;
    logic       rise;
    logic       accept;
    logic       rej_inc;
    logic [7:0] w_cfg;

    assign s     = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign w_cfg = (bus.cfg[7:0] == 8'd0) ? 8'd1 : bus.cfg[7:0];

    always_comb begin
        sync_d  = {sync_q[1:0], bus.dtctrg_in};
        state_d = state_q;
        wcnt_d  = wcnt_q;
        dcnt_d  = dcnt_q;
        w_d     = w_q;
        d_d     = d_q;
        accept  = 1'b0;
        rej_inc = 1'b0;

        if (!(bus.dtcclk_ok && bus.trg_enable)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        w_d    = w_cfg;
                        d_d    = bus.cfg[15:8];
                        wcnt_d = 8'd1;
                        // W=1 is already satisfied by the first high sample
                        if (w_cfg == 8'd1) begin
                            accept  = 1'b1;
                            dcnt_d  = bus.cfg[15:8];
                            state_d = DEAD;
                        end else begin
                            state_d = HIGH;
                        end
                    end
                end
                HIGH: begin
                    if (!s) begin
                        rej_inc = 1'b1;
                        state_d = IDLE;
                    end else if (wcnt_q + 8'd1 == w_q) begin
                        accept  = 1'b1;
                        dcnt_d  = d_q;
                        state_d = DEAD;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
                DEAD: begin
                    if (dcnt_q != 8'd0) begin
                        dcnt_d = dcnt_q - 8'd1;
                    end
                    if (rise) begin
                        rej_inc = 1'b1;
                    end
                    if (dcnt_q == 8'd0 && !s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pulse_d = accept;
        busy_d  = (state_d == DEAD);

        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end

        rej_d = rej_q;
        if (bus.cnt_clr) begin
            rej_d = '0;
        end else if (rej_inc && rej_q != '1) begin
            rej_d = rej_q + 1'b1;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
            w_q     <= '0;
            d_q     <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
            w_q     <= w_d;
            d_q     <= d_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
        end
    end

    assign bus.trg_pulse        = pulse_q;
    assign bus.trg_busy         = busy_q;
    assign bus.trg_count        = cnt_q;
    assign bus.trg_reject_count = rej_q;
endmodule

// File: tb/tb_dtcctf_trgunit.sv
// Directed bench for dtcctf_trgunit; narrow counters make wrap and saturation reachable.
module tb_dtcctf_trgunit;
    localparam int CNT_W = 4;
    localparam int REJ_W = 4;

    logic clk0 = 1'b0;
    logic rst;
    int   pass_n = 0;
    int   total_n = 0;
    int   np, brun, bmax;

    always #5 clk0 = ~clk0;

    dtcctf_trgunit_if #(.CNT_W(CNT_W), .REJ_W(REJ_W)) bus ();

    dtcctf_trgunit #(.CNT_W(CNT_W), .REJ_W(REJ_W)) dut (
        .clk0 (clk0),
        .rst  (rst),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // drive the trigger level, then step n edges while watching pulse/busy
    task automatic run(input logic din, input int n);
        bus.dtctrg_in = din;
        for (int i = 0; i < n; i++) begin
            @(posedge clk0);
            #1;
            if (bus.trg_pulse) np++;
            if (bus.trg_busy) begin
                brun++;
                if (brun > bmax) bmax = brun;
            end else begin
                brun = 0;
            end
        end
    endtask

    task automatic clr_cnt();
        bus.cnt_clr = 1'b1;
        run(1'b0, 1);
        bus.cnt_clr = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.dtctrg_in  = 1'b0;
        bus.dtcclk_ok  = 1'b1;
        bus.trg_enable = 1'b1;
        bus.cnt_clr    = 1'b0;
        bus.cfg        = 16'h0004;
        np = 0; brun = 0; bmax = 0;
        run(1'b0, 3);
        chk("rst_pulse", 32'(bus.trg_pulse), 32'd0);
        chk("rst_busy", 32'(bus.trg_busy), 32'd0);
        chk("rst_cnt", 32'(bus.trg_count), 32'd0);
        chk("rst_rej", 32'(bus.trg_reject_count), 32'd0);
        rst = 1'b0;
        run(1'b0, 2);

        // W=4 D=0, 10-cycle pulse: trigger W+2 edges after the first sampling edge
        bus.cfg = 16'h0004;
        np = 0;
        run(1'b1, 5);
        chk("w4_early", 32'(np), 32'd0);
        run(1'b1, 1);
        chk("w4_lat_pulse", 32'(bus.trg_pulse), 32'd1);
        chk("w4_lat_busy", 32'(bus.trg_busy), 32'd1);
        run(1'b1, 4);
        run(1'b0, 10);
        chk("w4_npulse", 32'(np), 32'd1);
        chk("w4_cnt", 32'(bus.trg_count), 32'd1);
        chk("w4_rej", 32'(bus.trg_reject_count), 32'd0);
        chk("w4_idle", 32'(bus.trg_busy), 32'd0);

        // W=4, 3-cycle pulse is rejected
        np = 0;
        run(1'b1, 3);
        run(1'b0, 10);
        chk("short_npulse", 32'(np), 32'd0);
        chk("short_rej", 32'(bus.trg_reject_count), 32'd1);
        chk("short_cnt", 32'(bus.trg_count), 32'd1);
        chk("short_idle", 32'(bus.trg_busy), 32'd0);

        // W=0 behaves as W=1
        bus.cfg = 16'h0000;
        np = 0;
        run(1'b1, 1);
        run(1'b0, 2);
        chk("w0_pulse", 32'(bus.trg_pulse), 32'd1);
        run(1'b0, 4);
        chk("w0_npulse", 32'(np), 32'd1);
        chk("w0_cnt", 32'(bus.trg_count), 32'd2);

        // W=1 D=20, 2-cycle pulses every 5 cycles for 40 cycles
        clr_cnt();
        bus.cfg = 16'h1401;
        np = 0; brun = 0; bmax = 0;
        for (int k = 0; k < 8; k++) begin
            run(1'b1, 2);
            run(1'b0, 3);
        end
        run(1'b0, 30);
        chk("dead_npulse", 32'(np), 32'd2);
        chk("dead_cnt", 32'(bus.trg_count), 32'd2);
        chk("dead_rej", 32'(bus.trg_reject_count), 32'd6);
        chk("dead_busy20", 32'(bmax >= 20), 32'd1);
        chk("dead_idle", 32'(bus.trg_busy), 32'd0);

        // dtcclk_ok dropped mid-HIGH, then trg_enable held low
        clr_cnt();
        bus.cfg = 16'h0004;
        np = 0;
        run(1'b1, 4);
        bus.dtcclk_ok = 1'b0;
        run(1'b1, 6);
        run(1'b0, 4);
        bus.dtcclk_ok = 1'b1;
        run(1'b0, 4);
        chk("gate_npulse", 32'(np), 32'd0);
        chk("gate_cnt", 32'(bus.trg_count), 32'd0);
        chk("gate_rej", 32'(bus.trg_reject_count), 32'd0);
        chk("gate_idle", 32'(bus.trg_busy), 32'd0);
        bus.cfg = 16'h0001;
        bus.trg_enable = 1'b0;
        run(1'b1, 1);
        run(1'b0, 6);
        bus.trg_enable = 1'b1;
        run(1'b0, 2);
        chk("en_npulse", 32'(np), 32'd0);
        chk("en_cnt", 32'(bus.trg_count), 32'd0);

        // cnt_clr in the same cycle as trg_pulse wins
        bus.cfg = 16'h0001;
        run(1'b1, 1);
        run(1'b0, 1);
        bus.cnt_clr = 1'b1;
        run(1'b0, 1);
        chk("clr_pulse", 32'(bus.trg_pulse), 32'd1);
        chk("clr_cnt", 32'(bus.trg_count), 32'd0);
        bus.cnt_clr = 1'b0;
        run(1'b0, 4);
        chk("clr_cnt_hold", 32'(bus.trg_count), 32'd0);

        // trg_count wraps at all-ones
        for (int k = 0; k < 15; k++) begin
            run(1'b1, 1);
            run(1'b0, 3);
        end
        chk("wrap_full", 32'(bus.trg_count), 32'hF);
        run(1'b1, 1);
        run(1'b0, 3);
        chk("wrap_zero", 32'(bus.trg_count), 32'd0);

        // reject counter saturates
        clr_cnt();
        bus.cfg = 16'h0004;
        for (int k = 0; k < 15; k++) begin
            run(1'b1, 2);
            run(1'b0, 4);
        end
        chk("sat_full", 32'(bus.trg_reject_count), 32'hF);
        run(1'b1, 2);
        run(1'b0, 4);
        chk("sat_hold", 32'(bus.trg_reject_count), 32'hF);
        chk("sat_cnt", 32'(bus.trg_count), 32'd0);

        // rst while in DEAD
        bus.cfg = 16'h1401;
        run(1'b1, 1);
        run(1'b0, 4);
        chk("rstd_busy_pre", 32'(bus.trg_busy), 32'd1);
        chk("rstd_cnt_pre", 32'(bus.trg_count), 32'd1);
        rst = 1'b1;
        run(1'b0, 1);
        chk("rstd_busy", 32'(bus.trg_busy), 32'd0);
        chk("rstd_pulse", 32'(bus.trg_pulse), 32'd0);
        chk("rstd_cnt", 32'(bus.trg_count), 32'd0);
        chk("rstd_rej", 32'(bus.trg_reject_count), 32'd0);
        rst = 1'b0;
        np = 0;
        run(1'b0, 10);
        chk("rstd_nopulse", 32'(np), 32'd0);
        chk("rstd_idle", 32'(bus.trg_busy), 32'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
